tag_lookup_unit: RTL and testbench
==================================

TAG_LOOKUP_UNIT -- requirements
Module: tag_lookup_unit

Interface
REQ-001 Parameter WAYS, default 4, associativity; SHALL be a power of two, at least 2.
REQ-002 Parameter TAG_W, default 16, tag width in bits.
REQ-003 Parameter SET_W, default 6, set index width; SETS = 2**SET_W.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 lkp_valid  in  1  lookup request valid.
REQ-007 lkp_ready  out  1  unit can accept a lookup.
REQ-008 lkp_set  in  SET_W  lookup set index.
REQ-009 lkp_tag  in  TAG_W  lookup tag.
REQ-010 res_valid  out  1  result valid, single-cycle pulse.
REQ-011 res_hit  out  1  tag matched a valid way.
REQ-012 res_way  out  clog2(WAYS)  hit way if res_hit, else victim way.
REQ-013 fill_valid  in  1  write tag into fill_set/fill_way and set its valid bit.
REQ-014 fill_set  in  SET_W; fill_way  in  clog2(WAYS); fill_tag  in  TAG_W.
REQ-015 flush_req  in  1  invalidate all entries.
REQ-016 busy  out  1  flush walk in progress.
REQ-017 multi_hit  out  1  more than one way matched; qualified by res_valid.

Function
REQ-018 Storage SHALL be SETS x WAYS entries of {valid, TAG_W tag}, plus one clog2(WAYS) round-robin pointer per set.
REQ-019 A lookup SHALL be accepted on a clk edge where lkp_valid && lkp_ready.
REQ-020 For an accepted lookup, res_valid SHALL assert exactly one cycle later, with no backpressure.
REQ-021 A way hits when its valid bit is 1 and its stored tag equals lkp_tag; res_hit SHALL be the OR of all way hits.
REQ-022 On a hit, res_way SHALL be the lowest-index hitting way.
REQ-023 On a miss, res_way SHALL be the victim: the lowest-index invalid way, else the set's round-robin pointer.
REQ-024 A lookup SHALL compare against state before any fill in the same cycle (read-before-write), including the same set and way.
REQ-025 A fill SHALL write the tag, set valid, and advance that set's pointer to (fill_way+1) mod WAYS.
REQ-026 A fill SHALL leave all other sets and ways unchanged.
REQ-027 FSM states are IDLE and FLUSH; IDLE -> FLUSH on flush_req=1.
REQ-028 FLUSH SHALL clear valid bits and pointers of one set per cycle, ascending from set 0.
REQ-029 FLUSH -> IDLE after set SETS-1 is cleared, taking exactly SETS cycles.
REQ-030 busy SHALL be 1 exactly while in FLUSH; lkp_ready SHALL equal !busy.
REQ-031 fill_valid during FLUSH SHALL be ignored.
REQ-032 flush_req during FLUSH SHALL be ignored; the walk is not restarted.
REQ-033 flush_req and fill_valid in the same IDLE cycle: the fill SHALL be discarded.
REQ-034 A lookup accepted in the cycle flush_req rises SHALL complete normally against pre-flush state.
REQ-035 When res_valid is 0, res_hit, res_way and multi_hit SHALL be 0.

Reset
REQ-036 RST=1 SHALL force the FSM into FLUSH starting at set 0, regardless of the current state.
REQ-037 While RST=1: res_valid=0, res_hit=0, res_way=0, multi_hit=0, busy=1, lkp_ready=0.
REQ-038 The first IDLE cycle after RST deasserts SHALL follow SETS flush cycles.
REQ-039 RST asserted mid-flush SHALL restart the walk at set 0.
REQ-040 RST SHALL drop any in-flight result.

Configuration
REQ-041 Macro TAG_MULTIHIT_CHECK_EN, when defined: multi_hit SHALL be 1 with res_valid when two or more ways hit.
REQ-042 When TAG_MULTIHIT_CHECK_EN is undefined: multi_hit SHALL be constant 0 and no popcount logic is built.
REQ-043 The macro SHALL NOT alter res_hit/res_way behaviour or latency.

Verification
REQ-044 Reset, SETS=64 -> busy=1 for 64 cycles, lkp_ready=1 on cycle 65; lookup set 5 tag 0x1234 -> res_hit=0, res_way=0.
REQ-045 Fill set 5 way 2 tag 0xABCD, then lookup set 5 tag 0xABCD -> next cycle res_valid=1, res_hit=1, res_way=2.
REQ-046 Fill set 3 ways 0-3, then lookup set 3 misses -> res_way=pointer=0; fill way 0, miss again -> res_way=1.
REQ-047 Same cycle: fill set 7 way 1 tag 0x55 and lookup set 7 tag 0x55 -> res_hit=0; repeated lookup next cycle -> res_hit=1, res_way=1.
REQ-048 With TAG_MULTIHIT_CHECK_EN, fill ways 1 and 3 of set 9 with tag 0x77, lookup -> res_hit=1, res_way=1, multi_hit=1; without the macro -> multi_hit=0.
REQ-049 flush_req with fill in the same cycle, RST pulsed at flush cycle 10 -> fill discarded, walk restarts, busy lasts 64 cycles after RST, all lookups miss afterwards.

Source files
------------

// File: rtl/tag_lookup_unit.sv
// Set-associative tag lookup with round-robin victim selection and a one-set-per-cycle flush walk.
// Optional multi-hit detection is built only when TAG_MULTIHIT_CHECK_EN is defined.
//
// state | meaning
// IDLE  | lookups and fills accepted
// FLUSH | clearing valid bits and pointers, one set per cycle from set 0
module tag_lookup_unit #(
    parameter int WAYS  = 4,
    parameter int TAG_W = 16,
    parameter int SET_W = 6
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     lkp_valid,
    output logic                     lkp_ready,
    input  logic [SET_W-1:0]         lkp_set,
    input  logic [TAG_W-1:0]         lkp_tag,
    output logic                     res_valid,
    output logic                     res_hit,
    output logic [$clog2(WAYS)-1:0]  res_way,
    input  logic                     fill_valid,
    input  logic [SET_W-1:0]         fill_set,
    input  logic [$clog2(WAYS)-1:0]  fill_way,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic                     flush_req,
    output logic                     busy,
    output logic                     multi_hit
);
    localparam int SETS  = 2**SET_W;
    localparam int WAY_W = $clog2(WAYS);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAY_W-1:0] ptr_q   [SETS];

    logic [0:0]       state_q;
    logic [SET_W-1:0] flush_set_q;

    logic             res_valid_q;
    logic             res_hit_q;
    logic [WAY_W-1:0] res_way_q;

    logic             lkp_accept;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lkp_way;

    assign busy       = RST || (state_q == FLUSH);
    assign lkp_ready  = !busy;
    assign lkp_accept = lkp_valid && lkp_ready;

    // Compare against the current array contents; same-cycle fills land at the edge afterwards.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[lkp_set][w] && (tag_q[lkp_set][w] == lkp_tag);
        end
    end

    assign hit_any = |hit_vec;
    assign inv_any = !(&valid_q[lkp_set]);

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_q[lkp_set][w]) begin
                inv_way = WAY_W'(w);
            end
        end
    end

    assign lkp_way = hit_any ? hit_way : (inv_any ? inv_way : ptr_q[lkp_set]);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= FLUSH;
            flush_set_q <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_way_q   <= '0;
        end else begin
            res_valid_q <= lkp_accept;
            res_hit_q   <= lkp_accept && hit_any;
            res_way_q   <= lkp_accept ? lkp_way : '0;
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q     <= FLUSH;
                        flush_set_q <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_set_q == SET_W'(SETS - 1)) begin
                        state_q <= IDLE;
                    end
                    flush_set_q <= flush_set_q + SET_W'(1);
                end
                default: state_q <= FLUSH;
            endcase
        end
    end

    // A fill colliding with a flush request is dropped; the walk would clear it anyway.
    always_ff @(posedge clk) begin
        if (!RST) begin
            if (state_q == FLUSH) begin
                valid_q[flush_set_q] <= '0;
                ptr_q[flush_set_q]   <= '0;
            end else if (fill_valid && !flush_req) begin
                tag_q[fill_set][fill_way]   <= fill_tag;
                valid_q[fill_set][fill_way] <= 1'b1;
                ptr_q[fill_set]             <= fill_way + WAY_W'(1);
            end
        end
    end

    assign res_valid = res_valid_q && !RST;
    assign res_hit   = res_hit_q && !RST;
    assign res_way   = RST ? '0 : res_way_q;

`ifdef TAG_MULTIHIT_CHECK_EN
    localparam int CNT_W = $clog2(WAYS + 1);

    logic [CNT_W-1:0] hit_cnt;
    logic             multi_q;

    always_comb begin
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_cnt = hit_cnt + CNT_W'(hit_vec[w]);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= lkp_accept && (hit_cnt >= CNT_W'(2));
        end
    end

    assign multi_hit = multi_q && !RST;
`else
    assign multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tag_lookup_unit.sv
// Scoreboard bench for tag_lookup_unit: drivers queue expected results, a negedge monitor checks them.
module tb_tag_lookup_unit;
    localparam int WAYS  = 4;
    localparam int TAG_W = 16;
    localparam int SET_W = 6;
    localparam int SETS  = 64;
`ifdef TAG_MULTIHIT_CHECK_EN
    localparam logic MH = 1'b1;
`else
    localparam logic MH = 1'b0;
`endif

    typedef struct packed {
        logic       hit;
        logic [1:0] way;
        logic       multi;
    } exp_t;

    logic             clk;
    logic             RST;
    logic             lkp_valid;
    logic             lkp_ready;
    logic [SET_W-1:0] lkp_set;
    logic [TAG_W-1:0] lkp_tag;
    logic             res_valid;
    logic             res_hit;
    logic [1:0]       res_way;
    logic             fill_valid;
    logic [SET_W-1:0] fill_set;
    logic [1:0]       fill_way;
    logic [TAG_W-1:0] fill_tag;
    logic             flush_req;
    logic             busy;
    logic             multi_hit;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   n;

    tag_lookup_unit #(.WAYS(WAYS), .TAG_W(TAG_W), .SET_W(SET_W)) dut (
        .clk        (clk),
        .RST        (RST),
        .lkp_valid  (lkp_valid),
        .lkp_ready  (lkp_ready),
        .lkp_set    (lkp_set),
        .lkp_tag    (lkp_tag),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .res_way    (res_way),
        .fill_valid (fill_valid),
        .fill_set   (fill_set),
        .fill_way   (fill_way),
        .fill_tag   (fill_tag),
        .flush_req  (flush_req),
        .busy       (busy),
        .multi_hit  (multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        lkp_valid  = 1'b0;
        fill_valid = 1'b0;
        flush_req  = 1'b0;
    endtask

    task automatic fill(input int s, input int w, input int t);
        @(negedge clk);
        idle_inputs();
        fill_valid = 1'b1;
        fill_set   = SET_W'(s);
        fill_way   = 2'(w);
        fill_tag   = TAG_W'(t);
    endtask

    task automatic lookup(input int s, input int t, input logic eh, input int ew, input logic em);
        @(negedge clk);
        idle_inputs();
        lkp_valid = 1'b1;
        lkp_set   = SET_W'(s);
        lkp_tag   = TAG_W'(t);
        exp_q.push_back('{hit: eh, way: 2'(ew), multi: em});
    endtask

    task automatic fill_and_lookup(input int s, input int w, input int t, input logic eh, input int ew);
        @(negedge clk);
        idle_inputs();
        fill_valid = 1'b1;
        fill_set   = SET_W'(s);
        fill_way   = 2'(w);
        fill_tag   = TAG_W'(t);
        lkp_valid  = 1'b1;
        lkp_set    = SET_W'(s);
        lkp_tag    = TAG_W'(t);
        exp_q.push_back('{hit: eh, way: 2'(ew), multi: 1'b0});
    endtask

    task automatic nop();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        forever begin
            #1;
            if (!busy || cnt >= 300) break;
            cnt++;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_hit", 32'(res_hit), 32'(e.hit));
                chk("res_way", 32'(res_way), 32'(e.way));
                chk("multi_hit", 32'(multi_hit), 32'(e.multi));
            end
        end else begin
            chk("idle_outputs_zero", 32'({res_hit, res_way, multi_hit}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        idle_inputs();
        lkp_set = '0; lkp_tag = '0; fill_set = '0; fill_way = '0; fill_tag = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_lkp_ready", 32'(lkp_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);

        @(negedge clk);
        RST = 1'b0;
        count_busy(n);
        chk("reset_busy_cycles", 32'(n), 32'd64);
        chk("ready_after_reset", 32'(lkp_ready), 32'd1);

        lookup(5, 'h1234, 1'b0, 0, 1'b0);
        fill(5, 2, 'hABCD);
        lookup(5, 'hABCD, 1'b1, 2, 1'b0);
        lookup(5, 'h1234, 1'b0, 0, 1'b0);
        lookup(6, 'hABCD, 1'b0, 0, 1'b0);

        for (int w = 0; w < 4; w++) fill(3, w, 'h100 + w);
        lookup(3, 'h999, 1'b0, 0, 1'b0);
        lookup(3, 'h102, 1'b1, 2, 1'b0);
        fill(3, 0, 'h200);
        lookup(3, 'h999, 1'b0, 1, 1'b0);
        lookup(3, 'h100, 1'b0, 1, 1'b0);

        fill_and_lookup(7, 1, 'h55, 1'b0, 0);
        lookup(7, 'h55, 1'b1, 1, 1'b0);

        fill(9, 1, 'h77);
        fill(9, 3, 'h77);
        lookup(9, 'h77, 1'b1, 1, MH);

        fill(63, 3, 'hFFFF);
        lookup(63, 'hFFFF, 1'b1, 3, 1'b0);
        lookup(0, 'hFFFF, 1'b0, 0, 1'b0);
        nop();
        nop();

        // Plain flush; a fill into an already-cleared set and a repeat request arrive mid-walk.
        @(negedge clk);
        idle_inputs();
        flush_req = 1'b1;
        @(negedge clk);
        idle_inputs();
        n = 0;
        forever begin
            #1;
            if (!busy || n >= 300) break;
            n++;
            @(negedge clk);
            idle_inputs();
            if (n == 5) begin
                fill_valid = 1'b1;
                fill_set   = SET_W'(1);
                fill_way   = 2'd0;
                fill_tag   = TAG_W'('h33);
                flush_req  = 1'b1;
            end
        end
        chk("flush_busy_cycles", 32'(n), 32'd64);
        lookup(1, 'h33, 1'b0, 0, 1'b0);
        lookup(5, 'hABCD, 1'b0, 0, 1'b0);

        fill(5, 2, 'hABCD);
        fill(3, 1, 'h102);
        lookup(3, 'h102, 1'b1, 1, 1'b0);

        // Flush with a colliding fill and lookup, then reset at flush cycle 10.
        @(negedge clk);
        idle_inputs();
        flush_req  = 1'b1;
        fill_valid = 1'b1;
        fill_set   = SET_W'(10);
        fill_way   = 2'd0;
        fill_tag   = TAG_W'('h42);
        lkp_valid  = 1'b1;
        lkp_set    = SET_W'(5);
        lkp_tag    = TAG_W'('hABCD);
        exp_q.push_back('{hit: 1'b1, way: 2'd2, multi: 1'b0});
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_not_ready", 32'(lkp_ready), 32'd0);
        repeat (9) @(negedge clk);
        RST = 1'b1;
        #1;
        chk("midflush_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        RST = 1'b0;
        count_busy(n);
        chk("rst_restart_busy_cycles", 32'(n), 32'd64);
        lookup(5, 'hABCD, 1'b0, 0, 1'b0);
        lookup(10, 'h42, 1'b0, 0, 1'b0);
        lookup(3, 'h102, 1'b0, 0, 1'b0);
        lookup(9, 'h77, 1'b0, 0, 1'b0);
        lookup(63, 'hFFFF, 1'b0, 0, 1'b0);
        nop();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
